codificador_pt2262: RTL and testbench

//  PT2262-compatible encoder; transmitting end of the decodificador_pt2272 link.

---
 rtl/pt2262_pkg.sv | 30 +++
 rtl/pt2262_tick_gen.sv | 28 ++
 rtl/codificador_pt2262.sv | 159 +++++++++++++++
 tb/tb_codificador_pt2262.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pt2262_pkg.sv
// PT2262/PT2272 shared waveform definitions.
// Contents: FSM state enum, the three 32-tick symbol patterns (index 0 sent
// first), sync word length, and a trit-to-pattern helper. The encoder and the
// decoder both import this package so that they use the same waveforms.
package pt2262_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    SYNC
  } state_t;

  // 1 tick = 1 receiver sample; 32 ticks per symbol.
  localparam logic [0:31] BIT_0 = 32'hF000_F000; // 4H 12L 4H 12L
  localparam logic [0:31] BIT_1 = 32'hFFF0_FFF0; // 12H 4L 12H 4L
  localparam logic [0:31] BIT_F = 32'hF000_FFF0; // 4H 12L 12H 4L

  localparam int unsigned SYM_LEN   = 32;
  localparam int unsigned SYNC_LEN  = 128;      // 4H 124L
  localparam int unsigned SYNC_HIGH = 4;

  // Float flag has priority over the 0/1 value.
  function automatic logic [0:31] trit_pattern(input logic v01, input logic vf);
    if (vf)       return BIT_F;
    else if (v01) return BIT_1;
    else          return BIT_0;
  endfunction

endpackage

// File: rtl/pt2262_tick_gen.sv
// Free-running tick enable generator.
// Produces a 1-clk tick every CLK_DIV clocks (divider counts 0..CLK_DIV-1,
// tick while divider == CLK_DIV-1). Replaces a derived clock.
// Ports:
//   clk   in  system clock
//   reset in  synchronous active-high reset (divider -> 0)
//   tick  out 1-clk enable pulse
module pt2262_tick_gen #(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div;

  assign tick = (div == DW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset)     div <= '0;
    else if (tick) div <= '0;
    else           div <= div + DW'(1);
  end

endmodule

// File: rtl/codificador_pt2262.sv
// PT2262-compatible encoder: serialises 8 trinary address trits, 4 data bits
// and a sync word onto cod_o on a 12 kHz tick grid (32 ticks per symbol,
// 512 ticks per frame). Frames repeat back-to-back while te is high.
// Ports:
//   clk        in  system clock (3 MHz nominal)
//   reset      in  synchronous active-high reset, aborts any frame
//   A_01[7:0]  in  address trit values (1='1', 0='0')
//   A_F[7:0]   in  address float flags (1='F', overrides A_01)
//   D[3:0]     in  data nibble, sent D[3] first
//   te         in  transmit enable, level-sensitive
//   cod_o      out encoded serial output, registered
//   busy       out high from frame start until the last frame ends
//   frame_done out 1-clk pulse after the tick that ends each sync word
// Configuration macro: PT2262_MIN4_EN -- when defined, every burst sends at
// least 4 frames regardless of how briefly te was held.
module codificador_pt2262
  import pt2262_pkg::*;
#(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] A_01,
  input  logic [7:0] A_F,
  input  logic [3:0] D,
  input  logic       te,
  output logic       cod_o,
  output logic       busy,
  output logic       frame_done
);

  logic        tick;
  state_t      state;
  logic [6:0]  phase;
  logic [2:0]  idx;
  logic [7:0]  a01_q;
  logic [7:0]  af_q;
  logic [3:0]  d_q;
  logic [0:31] cur_pat;
  logic [4:0]  sym_next;
  logic [6:0]  phase_inc;
  logic        repeat_due;

  pt2262_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_comb begin
    cur_pat = BIT_0;
    if (state == DATA) cur_pat = d_q[idx[1:0]] ? BIT_1 : BIT_0;
    else               cur_pat = trit_pattern(a01_q[idx], af_q[idx]);
  end

  // cod_o is registered one tick ahead: each tick loads the bit for the
  // position the counters are about to move to. Every pattern starts high,
  // so symbol and frame boundaries always load 1.
  assign sym_next  = phase[4:0] + 5'd1;
  assign phase_inc = phase + 7'd1;

`ifdef PT2262_MIN4_EN
  logic [1:0] fcnt;
  assign repeat_due = te || (fcnt != 2'd3);
`else
  assign repeat_due = te;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      phase      <= '0;
      idx        <= '0;
      a01_q      <= '0;
      af_q       <= '0;
      d_q        <= '0;
      cod_o      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef PT2262_MIN4_EN
      fcnt       <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            cod_o <= 1'b0;
            if (te) begin
              a01_q <= A_01;
              af_q  <= A_F;
              d_q   <= D;
              busy  <= 1'b1;
              state <= ADDR;
              idx   <= '0;
              phase <= '0;
              cod_o <= 1'b1;
`ifdef PT2262_MIN4_EN
              fcnt  <= '0;
`endif
            end
          end
          ADDR: begin
            if (phase == 7'(SYM_LEN - 1)) begin
              phase <= '0;
              cod_o <= 1'b1;
              if (idx == 3'd7) begin
                state <= DATA;
                idx   <= 3'd3;
              end else begin
                idx <= idx + 3'd1;
              end
            end else begin
              phase <= phase_inc;
              cod_o <= cur_pat[sym_next];
            end
          end
          DATA: begin
            if (phase == 7'(SYM_LEN - 1)) begin
              phase <= '0;
              cod_o <= 1'b1;
              if (idx == 3'd0) state <= SYNC;
              else             idx   <= idx - 3'd1;
            end else begin
              phase <= phase_inc;
              cod_o <= cur_pat[sym_next];
            end
          end
          SYNC: begin
            if (phase == 7'(SYNC_LEN - 1)) begin
              frame_done <= 1'b1;
              phase      <= '0;
`ifdef PT2262_MIN4_EN
              if (fcnt != 2'd3) fcnt <= fcnt + 2'd1;
`endif
              if (repeat_due) begin
                a01_q <= A_01;
                af_q  <= A_F;
                d_q   <= D;
                state <= ADDR;
                idx   <= '0;
                cod_o <= 1'b1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
                cod_o <= 1'b0;
              end
            end else begin
              phase <= phase_inc;
              cod_o <= (phase_inc < 7'(SYNC_HIGH));
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_codificador_pt2262.sv
// Bench for codificador_pt2262 with CLK_DIV=4. Stimulus pushes the expected
// 32-tick words of each frame into a queue; a monitor reassembles cod_o into
// words while busy is high and compares them against the queue.
module tb_codificador_pt2262;

  localparam int unsigned DIV = 4;
`ifdef PT2262_MIN4_EN
  localparam int MIN_FRAMES = 4;
`else
  localparam int MIN_FRAMES = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] a01 = '0;
  logic [7:0] af = '0;
  logic [3:0] d = '0;
  logic       te = 1'b0;
  logic       cod_o;
  logic       busy;
  logic       frame_done;

  codificador_pt2262 #(.CLK_DIV(DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .A_01       (a01),
    .A_F        (af),
    .D          (d),
    .te         (te),
    .cod_o      (cod_o),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int fd_cnt = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Hand-written waveforms, first tick in the MSB.
  localparam logic [31:0] W0    = 32'hF000_F000;
  localparam logic [31:0] W1    = 32'hFFF0_FFF0;
  localparam logic [31:0] WF    = 32'hF000_FFF0;
  localparam logic [31:0] WSYNC = 32'hF000_0000;

  task automatic push_frame(input logic [7:0] va, input logic [7:0] vf, input logic [3:0] vd);
    for (int i = 0; i < 8; i++)
      exp_q.push_back(vf[i] ? WF : (va[i] ? W1 : W0));
    for (int b = 3; b >= 0; b--)
      exp_q.push_back(vd[b] ? W1 : W0);
    exp_q.push_back(WSYNC);
    for (int k = 0; k < 3; k++) exp_q.push_back(32'h0);
  endtask

  // Monitor: sample cod_o once per tick interval from the first clock busy
  // is seen high; each frame is exactly 512 samples.
  bit          in_burst = 1'b0;
  int          sub = 0;
  int          s = 0;
  int          nb = 0;
  logic [31:0] w = '0;
  logic [31:0] exp_w;

  task take_sample;
    if (s > 0 && s % 512 == 0) begin
      check($sformatf("frame_done_at_%0d", s), {31'b0, frame_done}, 32'd1);
      if (!busy) begin
        check("cod_o_after_burst", {31'b0, cod_o}, 32'd0);
        in_burst = 1'b0;
        return;
      end
    end
    if (!busy) begin
      check($sformatf("busy_held_%0d", s), {31'b0, busy}, 32'd1);
      in_burst = 1'b0;
      return;
    end
    w = {w[30:0], cod_o};
    nb++;
    s++;
    if (nb == 32) begin
      nb = 0;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %h expected none", w);
      end else begin
        exp_w = exp_q.pop_front();
        check($sformatf("word_%0d", (s - 1) / 32), w, exp_w);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      in_burst = 1'b0;
    end else if (!in_burst) begin
      if (busy) begin
        in_burst = 1'b1;
        sub = 0; s = 0; nb = 0; w = '0;
        take_sample();
      end
    end else begin
      sub++;
      if (sub == DIV) begin
        sub = 0;
        take_sample();
      end
    end
  end

  always @(negedge clk) if (!reset && frame_done) fd_cnt++;

  task automatic wait_busy(input string name);
    int n = 0;
    while (!busy && n < 100) begin @(posedge clk); n++; end
    #1;
    check({name, "_busy_rise"}, {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 40000) begin @(posedge clk); n++; end
    @(negedge clk);
    @(posedge clk);
    #1;
    check({name, "_idle"}, {31'b0, busy}, 32'd0);
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_te;
    @(posedge clk); #1;
    te = 1'b1;
    repeat (DIV) @(posedge clk);
    #1;
    te = 1'b0;
  endtask

  int fd0;
  int n;

  initial begin
    repeat (5) @(posedge clk);
    #1;
    check("reset_cod_o", {31'b0, cod_o}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_frame_done", {31'b0, frame_done}, 32'd0);
    reset = 1'b0;

    // 1: all '0', single-tick te pulse.
    a01 = 8'h00; af = 8'h00; d = 4'h0;
    for (int f = 0; f < MIN_FRAMES; f++) push_frame(a01, af, d);
    fd0 = fd_cnt;
    pulse_te();
    wait_busy("t1");
    wait_idle("t1");
    check("t1_frames", 32'(fd_cnt - fd0), 32'(MIN_FRAMES));

    // 2: trits 0,1,F,0,1,F,0,1 and D=1010.
    a01 = 8'b1001_0010; af = 8'b0010_0100; d = 4'b1010;
    for (int f = 0; f < MIN_FRAMES; f++) push_frame(a01, af, d);
    fd0 = fd_cnt;
    pulse_te();
    wait_busy("t2");
    wait_idle("t2");
    check("t2_frames", 32'(fd_cnt - fd0), 32'(MIN_FRAMES));

    // 3: te held across three frames, D changed mid first frame.
    a01 = 8'b0101_1010; af = 8'b1000_0001; d = 4'h3;
    push_frame(a01, af, 4'h3);
    push_frame(a01, af, 4'hC);
    push_frame(a01, af, 4'hC);
    if (MIN_FRAMES > 3) push_frame(a01, af, 4'hC);
    fd0 = fd_cnt;
    @(posedge clk); #1;
    te = 1'b1;
    wait_busy("t3");
    repeat (100) @(posedge clk);
    #1;
    d = 4'hC;
    n = 0;
    while (fd_cnt < fd0 + 2 && n < 20000) begin @(posedge clk); n++; end
    check("t3_two_frames_seen", 32'(fd_cnt - fd0), 32'd2);
    repeat (100) @(posedge clk);
    #1;
    te = 1'b0;
    wait_idle("t3");
    check("t3_frames", 32'(fd_cnt - fd0), 32'((MIN_FRAMES > 3) ? MIN_FRAMES : 3));

    // 4: reset around tick 200 with te still high.
    a01 = 8'b1100_0011; af = 8'b0000_1000; d = 4'h5;
    push_frame(a01, af, d);
    @(posedge clk); #1;
    te = 1'b1;
    wait_busy("t4");
    repeat (200 * DIV) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t4_reset_cod_o", {31'b0, cod_o}, 32'd0);
    check("t4_reset_busy", {31'b0, busy}, 32'd0);
    exp_q.delete();
    for (int f = 0; f < MIN_FRAMES; f++) push_frame(a01, af, d);
    fd0 = fd_cnt;
    reset = 1'b0;
    wait_busy("t4_restart");
    repeat (400) @(posedge clk);
    #1;
    te = 1'b0;
    wait_idle("t4");
    check("t4_frames", 32'(fd_cnt - fd0), 32'(MIN_FRAMES));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
